// File: rtl/kamikaze_compress_encoder_if.sv
// Handshake bundle for kamikaze_compress_encoder.
// The slave modport is the encoder's view; master is the producer/consumer side.
interface kamikaze_compress_encoder_if;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] instr_i;
    logic        flush_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] word_o;
    logic [15:0] comp_cnt_o;

    modport slave (
        input  in_valid_i, instr_i, flush_i, out_ready_i,
        output in_ready_o, out_valid_o, word_o, comp_cnt_o
    );

    modport master (
        output in_valid_i, instr_i, flush_i, out_ready_i,
        input  in_ready_o, out_valid_o, word_o, comp_cnt_o
    );
endinterface

// File: rtl/kamikaze_compress_encoder.sv
// kamikaze_compress_encoder: compresses RV32I instructions to RVC where a
// bit-exact 16-bit form exists and packs the resulting stream into 32-bit
// words through a one-halfword pending register.
// Optional feature macro: KMKZ_COMP_CTRL_EN -- when defined, jal x0/x1 and
// beq/bne rs1',x0 are also compressed (c.j/c.jal, c.beqz/c.bnez).
module kamikaze_compress_encoder (
    input logic                         clk,
    input logic                         rst_n,
    kamikaze_compress_encoder_if.slave  bus
);

    localparam int DATA_W = 32;
    localparam int HALF_W = DATA_W / 2;

    typedef enum logic {EMPTY = 1'b0, HALF = 1'b1} state_e;

    typedef struct packed {
        logic              ok;
        logic [HALF_W-1:0] c;
    } comp_t;

    // Saturating increment for the compressed-instruction counter.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Returns the RVC form of w when one exists; first matching rule wins.
    function automatic comp_t compress(input logic [DATA_W-1:0] w);
        logic [6:0]         opc;
        logic [2:0]         f3;
        logic [6:0]         f7;
        logic [4:0]         rd, rs1, rs2;
        logic signed [11:0] i_imm, s_imm;
        logic               fit6, rd_c, rs1_c, rs2_c;
        logic               is_addi, is_add, is_lw, is_sw, is_jalr;
`ifdef KMKZ_COMP_CTRL_EN
        logic signed [12:0] b_imm;
        logic signed [20:0] j_imm;
`endif
        comp_t              r;
        opc     = w[6:0];
        f3      = w[14:12];
        f7      = w[31:25];
        rd      = w[11:7];
        rs1     = w[19:15];
        rs2     = w[24:20];
        i_imm   = $signed(w[31:20]);
        s_imm   = $signed({w[31:25], w[11:7]});
        fit6    = (i_imm >= -12'sd32) && (i_imm <= 12'sd31);
        rd_c    = (rd[4:3] == 2'b01);
        rs1_c   = (rs1[4:3] == 2'b01);
        rs2_c   = (rs2[4:3] == 2'b01);
        is_addi = (opc == 7'b0010011) && (f3 == 3'b000);
        is_add  = (opc == 7'b0110011) && (f3 == 3'b000) && (f7 == 7'b0000000);
        is_lw   = (opc == 7'b0000011) && (f3 == 3'b010);
        is_sw   = (opc == 7'b0100011) && (f3 == 3'b010);
        is_jalr = (opc == 7'b1100111) && (f3 == 3'b000);
`ifdef KMKZ_COMP_CTRL_EN
        b_imm   = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0});
        j_imm   = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0});
`endif
        r.ok = 1'b1;
        r.c  = '0;
        if (is_addi && rd == 5'd0 && rs1 == 5'd0 && i_imm == 12'sd0)
            r.c = 16'h0001;
        else if (is_addi && rd != 5'd0 && rs1 == rd && i_imm != 12'sd0 && fit6)
            r.c = {3'b000, i_imm[5], rd, i_imm[4:0], 2'b01};
        else if (is_addi && rd != 5'd0 && rs1 == 5'd0 && fit6)
            r.c = {3'b010, i_imm[5], rd, i_imm[4:0], 2'b01};
        else if (is_add && rd != 5'd0 && rs2 != 5'd0 && rs1 == 5'd0)
            r.c = {3'b100, 1'b0, rd, rs2, 2'b10};
        else if (is_add && rd != 5'd0 && rs2 != 5'd0 && rs1 == rd)
            r.c = {3'b100, 1'b1, rd, rs2, 2'b10};
        else if (is_lw && rd_c && rs1_c && i_imm[11:7] == 5'd0 && i_imm[1:0] == 2'd0)
            r.c = {3'b010, i_imm[5:3], rs1[2:0], i_imm[2], i_imm[6], rd[2:0], 2'b00};
        else if (is_sw && rs2_c && rs1_c && s_imm[11:7] == 5'd0 && s_imm[1:0] == 2'd0)
            r.c = {3'b110, s_imm[5:3], rs1[2:0], s_imm[2], s_imm[6], rs2[2:0], 2'b00};
        else if (is_lw && rs1 == 5'd2 && rd != 5'd0 && i_imm[11:8] == 4'd0 && i_imm[1:0] == 2'd0)
            r.c = {3'b010, i_imm[5], rd, i_imm[4:2], i_imm[7:6], 2'b10};
        else if (is_sw && rs1 == 5'd2 && s_imm[11:8] == 4'd0 && s_imm[1:0] == 2'd0)
            r.c = {3'b110, s_imm[5:2], s_imm[7:6], rs2, 2'b10};
        else if (is_jalr && rs1 != 5'd0 && i_imm == 12'sd0 && rd[4:1] == 4'd0)
            r.c = {3'b100, rd[0], rs1, 5'd0, 2'b10};
`ifdef KMKZ_COMP_CTRL_EN
        else if (opc == 7'b1101111 && rd[4:1] == 4'd0 &&
                 j_imm >= -21'sd2048 && j_imm <= 21'sd2046)
            r.c = {rd[0] ? 3'b001 : 3'b101, j_imm[11], j_imm[4], j_imm[9:8], j_imm[10],
                   j_imm[6], j_imm[7], j_imm[3:1], j_imm[5], 2'b01};
        else if (opc == 7'b1100011 && f3[2:1] == 2'b00 && rs2 == 5'd0 && rs1_c &&
                 b_imm >= -13'sd256 && b_imm <= 13'sd254)
            r.c = {2'b11, f3[0], b_imm[8], b_imm[4:3], rs1[2:0], b_imm[7:6],
                   b_imm[2:1], b_imm[5], 2'b01};
`endif
        else
            r.ok = 1'b0;
        return r;
    endfunction

    state_e            state_q, state_d;
    logic [HALF_W-1:0] p_q, p_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic              out_valid_q, out_valid_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              in_ready;
    logic              accept;
    comp_t             cmp;

    // Next-state for the packer: input acceptance wins over flush.
    always_comb begin
        in_ready    = !out_valid_q || bus.out_ready_i;
        accept      = bus.in_valid_i && in_ready;
        cmp         = compress(bus.instr_i);
        state_d     = state_q;
        p_d         = p_q;
        word_d      = word_q;
        out_valid_d = out_valid_q && !bus.out_ready_i;
        cnt_d       = cnt_q;
        if (accept) begin
            if (cmp.ok)
                cnt_d = sat_inc(cnt_q);
            if (state_q == EMPTY) begin
                if (cmp.ok) begin
                    p_d     = cmp.c;
                    state_d = HALF;
                end else begin
                    word_d      = bus.instr_i;
                    out_valid_d = 1'b1;
                end
            end else begin
                out_valid_d = 1'b1;
                if (cmp.ok) begin
                    word_d  = {cmp.c, p_q};
                    state_d = EMPTY;
                end else begin
                    word_d = {bus.instr_i[15:0], p_q};
                    p_d    = bus.instr_i[31:16];
                end
            end
        end else if (bus.flush_i && in_ready && state_q == HALF) begin
            // Pad the lone halfword with c.nop so the word stays decodable.
            word_d      = {16'h0001, p_q};
            out_valid_d = 1'b1;
            state_d     = EMPTY;
        end
    end

    // State and output registers; reset discards any pending halfword.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            p_q         <= '0;
            word_q      <= '0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            p_q         <= p_d;
            word_q      <= word_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = out_valid_q;
    assign bus.word_o      = word_q;
    assign bus.comp_cnt_o  = cnt_q;

endmodule

// File: tb/tb_kamikaze_compress_encoder.sv
// Directed bench for kamikaze_compress_encoder with an output scoreboard.
// Honours KMKZ_COMP_CTRL_EN the same way the design does.
module tb_kamikaze_compress_encoder;

    logic clk;
    logic rst_n;

    kamikaze_compress_encoder_if bus();

    kamikaze_compress_encoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;

    // Compressible pairs: each pair packs into one word {second, first}.
    logic [31:0] pair_in [12] = '{
        32'hFFF00513, 32'h00B00533,   // c.li a0,-1   / c.mv a0,a1
        32'h00B50533, 32'h00442483,   // c.add a0,a1  / c.lw s1,4(s0)
        32'h0697AE23, 32'h0FC12083,   // c.sw s1,124(a5) / c.lwsp ra,252
        32'h00812423, 32'h00008067,   // c.swsp s0,8  / c.jr ra
        32'h000280E7, 32'hFE010113,   // c.jalr t0    / c.addi sp,-32
        32'h00000013, 32'h00000013    // c.nop        / c.nop
    };
    logic [31:0] pair_out [6] = '{
        32'h852E557D, 32'h4044952E, 32'h50FEDFE4,
        32'h8082C422, 32'h11019282, 32'h00010001
    };
    // Not compressible: 16-bit-looking opcode, addi out of range, lw offset
    // out of range, addi with zero immediate on rd!=0.
    logic [31:0] pass_in [4] = '{
        32'h00004501, 32'h02040413, 32'h08042483, 32'h00040413
    };

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] instr);
        logic acc;
        acc = 1'b0;
        bus.in_valid_i = 1'b1;
        bus.instr_i    = instr;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.in_ready_o) begin
                acc = 1'b1;
                break;
            end
        end
        chk("accept_timeout", {31'd0, acc}, 32'd1);
        if (acc) begin
            @(posedge clk);
            #1;
        end
        bus.in_valid_i = 1'b0;
    endtask

    task automatic flush();
        bus.flush_i = 1'b1;
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Output monitor: every handshake pops one expected word.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid_o && bus.out_ready_i) begin
            n_cmp++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL out_unexpected: observed word %h, expected no output", bus.word_o);
            end
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                chk("out_word", bus.word_o, mon_exp);
            end
        end
    end

    initial begin
        rst_n           = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.instr_i     = '0;
        bus.flush_i     = 1'b0;
        bus.out_ready_i = 1'b1;
        #12;
        chk("rst_out_valid", {31'd0, bus.out_valid_o}, 32'd0);
        chk("rst_word",      bus.word_o, 32'd0);
        chk("rst_cnt",       {16'd0, bus.comp_cnt_o}, 32'd0);
        chk("rst_in_ready",  {31'd0, bus.in_ready_o}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        chk("post_rst_in_ready", {31'd0, bus.in_ready_o}, 32'd1);

        // Two c.addi pack into one word.
        drive(32'h00140413);
        chk("half_no_out", {31'd0, bus.out_valid_o}, 32'd0);
        exp_q.push_back(32'h04050405);
        drive(32'h00140413);
        idle(2);
        chk("cnt_two_addi", {16'd0, bus.comp_cnt_o}, 32'd2);

        // 32-bit word in EMPTY goes straight out next cycle; flush in EMPTY is ignored.
        exp_q.push_back(32'h123450B7);
        drive(32'h123450B7);
        chk("lat_valid", {31'd0, bus.out_valid_o}, 32'd1);
        chk("lat_word",  bus.word_o, 32'h123450B7);
        idle(1);
        flush();
        idle(2);
        chk("empty_flush_quiet", {31'd0, bus.out_valid_o}, 32'd0);

        // Straddling word, then flush pads with c.nop.
        drive(32'h00140413);
        exp_q.push_back(32'h50B70405);
        drive(32'h123450B7);
        exp_q.push_back(32'h00011234);
        flush();
        idle(2);
        chk("cnt_after_straddle", {16'd0, bus.comp_cnt_o}, 32'd3);

        // Every compressed form, paired.
        for (int k = 0; k < 6; k++) begin
            drive(pair_in[2*k]);
            exp_q.push_back(pair_out[k]);
            drive(pair_in[2*k+1]);
        end
        idle(2);
        chk("cnt_after_pairs", {16'd0, bus.comp_cnt_o}, 32'd15);

        // Boundary cases that must stay 32-bit.
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(pass_in[k]);
            drive(pass_in[k]);
        end
        idle(2);
        chk("cnt_after_pass", {16'd0, bus.comp_cnt_o}, 32'd15);

        // Control-transfer forms: jal x0,8 and bne s1,x0,-4.
`ifdef KMKZ_COMP_CTRL_EN
        drive(32'h0080006F);
        exp_q.push_back(32'h0001A021);
        flush();
        drive(32'hFE049EE3);
        exp_q.push_back(32'h0001FCF5);
        flush();
        idle(2);
        chk("cnt_after_ctrl", {16'd0, bus.comp_cnt_o}, 32'd17);
`else
        exp_q.push_back(32'h0080006F);
        drive(32'h0080006F);
        flush();
        exp_q.push_back(32'hFE049EE3);
        drive(32'hFE049EE3);
        flush();
        idle(2);
        chk("cnt_after_ctrl", {16'd0, bus.comp_cnt_o}, 32'd15);
`endif

        // Backpressure: output held, no acceptance, nothing lost.
        bus.out_ready_i = 1'b0;
        exp_q.push_back(32'h123450B7);
        drive(32'h123450B7);
        exp_q.push_back(32'h00ABC537);
        bus.in_valid_i = 1'b1;
        bus.instr_i    = 32'h00ABC537;
        repeat (3) begin
            @(negedge clk);
            chk("stall_in_ready", {31'd0, bus.in_ready_o}, 32'd0);
            chk("stall_valid",    {31'd0, bus.out_valid_o}, 32'd1);
            chk("stall_word",     bus.word_o, 32'h123450B7);
        end
        @(posedge clk);
        #1;
        bus.out_ready_i = 1'b1;
        drive(32'h00ABC537);
        idle(2);

        // Reset while HALF with a word waiting: everything cleared at once.
        bus.out_ready_i = 1'b0;
        drive(32'h00140413);
        drive(32'h123450B7);
        chk("pre_rst_valid", {31'd0, bus.out_valid_o}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, bus.out_valid_o}, 32'd0);
        chk("async_rst_word",  bus.word_o, 32'd0);
        chk("async_rst_cnt",   {16'd0, bus.comp_cnt_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready_i = 1'b1;
        idle(1);
        flush();
        idle(2);
        chk("flush_after_rst_quiet", {31'd0, bus.out_valid_o}, 32'd0);
        chk("in_ready_after_rst",    {31'd0, bus.in_ready_o}, 32'd1);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/kamikaze_compress_encoder.md
KAMIKAZE_COMPRESS_ENCODER -- requirements
Module: kamikaze_compress_encoder

Interface
REQ-001 SHALL have ports, clock and reset first:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid_i  input  1  instr_i is offered
- in_ready_o  output  1  encoder accepts instr_i this cycle
- instr_i  input  32  RV32I instruction to compress/pack
- flush_i  input  1  request to drain the pending halfword
- out_valid_o  output  1  word_o valid
- out_ready_i  input  1  consumer accepts word_o
- word_o  output  32  packed instruction-stream word
- comp_cnt_o  output  16  count of instructions emitted in compressed form
REQ-002 SHALL have one clock (clk); reset rst_n is asynchronous and active-low.

Function
REQ-003 SHALL accept an input on a cycle where in_valid_i and in_ready_o are both high.
REQ-004 SHALL drive in_ready_o = !out_valid_o || out_ready_i; the output register is one entry.
REQ-005 SHALL register word_o and out_valid_o, one cycle after acceptance or flush; word_o is stable while out_valid_o && !out_ready_i.
REQ-006 SHALL pass any instr_i with [1:0] != 2'b11 through as a non-compressible 32-bit word, unmodified.
REQ-007 SHALL compress these, first match wins:
- addi x0,x0,0 -> c.nop
- addi rd,rd,imm, rd!=0, imm!=0, imm in [-32,31] -> c.addi
- addi rd,x0,imm, rd!=0, imm in [-32,31] -> c.li
- add rd,x0,rs2, rd,rs2!=0 -> c.mv
- add rd,rd,rs2, rd,rs2!=0 -> c.add
- lw/sw with rd'/rs2', rs1' in x8..x15, offset 0..124, multiple of 4 -> c.lw/c.sw
- lw rd,off(x2), rd!=0 / sw rs2,off(x2), offset 0..252, multiple of 4 -> c.lwsp/c.swsp
- jalr x0,0(rs1) / jalr x1,0(rs1), rs1!=0 -> c.jr/c.jalr
REQ-008 SHALL encode each compressed form so that the RVC decoder expands it back to the original instruction bit-exactly.
REQ-009 SHALL copy branch/jump offsets unchanged; PC fix-up after packing is the caller's responsibility.
REQ-010 SHALL use state EMPTY / HALF, with a 16-bit pending register P.
REQ-011 EMPTY with compressed C: P<=C, go HALF, no output.
REQ-012 EMPTY with 32-bit W: emit W, stay EMPTY.
REQ-013 HALF with compressed C: emit {C,P}, go EMPTY.
REQ-014 HALF with 32-bit W: emit {W[15:0],P}, P<=W[31:16], stay HALF.
REQ-015 flush_i in HALF with no acceptance that cycle (and in_ready_o high): emit {16'h0001,P}, go EMPTY.
REQ-016 flush_i in EMPTY SHALL be ignored; flush_i coincident with an acceptance SHALL be ignored (input wins).
REQ-017 SHALL increment comp_cnt_o per accepted compressed instruction, saturating at 16'hFFFF.

Reset
REQ-018 SHALL on rst_n low immediately force state EMPTY, P=0, out_valid_o=0, word_o=0, comp_cnt_o=0; a pending halfword is discarded.
REQ-019 SHALL hold in_ready_o=1 after reset release.

Configuration
REQ-020 SHALL, with KMKZ_COMP_CTRL_EN defined, also compress jal x0/x1 with offset in [-2048,2046] to c.j/c.jal, and beq/bne rs1',x0 with offset in [-256,254] to c.beqz/c.bnez.
REQ-021 SHALL, without KMKZ_COMP_CTRL_EN, pass those instructions as 32-bit words.

Verification
REQ-022 Two accepts of 0x00140413 (addi x8,x8,1) -> single word 0x04050405, comp_cnt_o=2.
REQ-023 0x123450B7 in EMPTY -> word_o=0x123450B7 next cycle, state EMPTY.
REQ-024 0x00140413 then 0x123450B7 -> 0x50B70405; then flush_i -> 0x00011234.
REQ-025 out_ready_i low 3 cycles while out_valid_o -> word_o stable, in_ready_o=0, no acceptance, no loss.
REQ-026 rst_n low while HALF and out_valid_o=1 -> out_valid_o=0 at once; a subsequent flush_i emits nothing.
REQ-027 0x0080006F (jal x0,8) then flush_i -> with KMKZ_COMP_CTRL_EN: 0x0001A021; without it: 0x0080006F and flush emits nothing.
